output_deserializer: RTL and testbench

OUTPUT_DESERIALIZER -- requirements
Module: output_deserializer

---
 rtl/output_deserializer.sv | 143 ++++++++++++++
 tb/tb_output_deserializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/output_deserializer.sv
// Collects a framed stream of serial words into one wide parallel word.
// Well-formed frames are published in one step; short or long frames are flagged and dropped.
module output_deserializer #(
  parameter int numWords     = 10,
  parameter int dataWidth    = 16,
  parameter int counterWidth = $clog2(numWords + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [dataWidth-1:0]          serialIn,
  input  logic                          serialValid,
  input  logic                          serialLast,
  output logic [dataWidth*numWords-1:0] parallelOut,
  output logic                          parallelValid,
  output logic                          frameError,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISCARD
  } state_t;

  localparam logic [counterWidth-1:0] LastIdx = counterWidth'(numWords - 1);

  state_t                          state, state_next;
  logic [counterWidth-1:0]         word_count, count_next;
  logic                            store_en;
  logic                            commit;
  logic                            error;
  logic [dataWidth*numWords-1:0]   next_frame;

  // The final word goes straight into the published frame, so staging holds only the first numWords-1 words.
  logic [dataWidth-1:0]            staging [numWords-1];

  // NOTE: state and counter use non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word_count <= '0;
    end else begin
      state      <= state_next;
      word_count <= count_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    count_next = word_count;
    store_en   = 1'b0;
    commit     = 1'b0;
    error      = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (serialValid) begin
          if (serialLast) begin
            error = 1'b1;
          end else begin
            store_en   = 1'b1;
            count_next = counterWidth'(1);
            state_next = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (serialValid) begin
          if (serialLast) begin
            count_next = '0;
            state_next = IDLE;
            if (word_count == LastIdx) begin
              store_en = 1'b1;
              commit   = 1'b1;
            end else begin
              error = 1'b1;
            end
          end else if (word_count == LastIdx) begin
            error      = 1'b1;
            count_next = '0;
            state_next = DISCARD;
          end else begin
            store_en   = 1'b1;
            count_next = word_count + counterWidth'(1);
          end
        end
      end

      DISCARD: begin
        if (serialValid && serialLast) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // NOTE: the staging buffer is not reset; each slot is rewritten before any good frame can publish it.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int k = 0; k < numWords - 1; k++) begin
        if (word_count == counterWidth'(k)) begin
          staging[k] <= serialIn;
        end
      end
    end
  end

  always_comb begin
    next_frame = '0;
    for (int k = 0; k < numWords - 1; k++) begin
      next_frame[k*dataWidth +: dataWidth] = staging[k];
    end
    next_frame[(numWords-1)*dataWidth +: dataWidth] = serialIn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      parallelOut   <= '0;
      parallelValid <= 1'b0;
      frameError    <= 1'b0;
    end else begin
      parallelValid <= commit;
      frameError    <= error;
      if (commit) begin
        parallelOut <= next_frame;
      end
    end
  end

  a_pulses_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(parallelValid && frameError));
  a_count_bounded : assert property (@(posedge clk) disable iff (reset)
    word_count <= LastIdx);

endmodule

// File: tb/tb_output_deserializer.sv
// Directed bench for output_deserializer: good, short, long, back-to-back, reset and single-word frames.
// Inputs change on the falling edge; outputs are read on the falling edge after the accepting rising edge.
module tb_output_deserializer;

  localparam int NW = 10;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     serialIn;
  logic              serialValid;
  logic              serialLast;
  logic [DW*NW-1:0]  parallelOut;
  logic              parallelValid;
  logic              frameError;
  logic              busy;

  int tests  = 0;
  int failed = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;

  logic [DW*NW-1:0] exp_out;

  output_deserializer #(.numWords(NW), .dataWidth(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .serialIn     (serialIn),
    .serialValid  (serialValid),
    .serialLast   (serialLast),
    .parallelOut  (parallelOut),
    .parallelValid(parallelValid),
    .frameError   (frameError),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (parallelValid) pv_cnt++;
      if (frameError)    fe_cnt++;
      tests++;
      if (parallelValid && frameError) begin
        failed++;
        $display("FAIL pulse_exclusive: parallelValid=%b frameError=%b, required not both high", parallelValid, frameError);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [DW-1:0] d, input logic v, input logic l);
    @(negedge clk);
    serialIn    = d;
    serialValid = v;
    serialLast  = l;
  endtask

  task automatic settle();
    drive('0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic make_frame(input logic [DW-1:0] base);
    for (int k = 0; k < NW; k++) exp_out[k*DW +: DW] = base + DW'(k);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    serialIn = '0; serialValid = 1'b0; serialLast = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (parallelOut !== '0) begin failed++; $display("FAIL reset_out: got %h required 0", parallelOut); end
    tests++; if (parallelValid !== 1'b0) begin failed++; $display("FAIL reset_pv: got %b required 0", parallelValid); end
    tests++; if (frameError !== 1'b0) begin failed++; $display("FAIL reset_fe: got %b required 0", frameError); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b required 0", busy); end
    reset = 1'b0;
    settle();
  endtask

  task automatic test_good_frame();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    make_frame(16'h0001);
    for (int i = 0; i < NW; i++) begin
      drive(16'h0001 + DW'(i), 1'b1, i == NW - 1);
      if (i == 5) begin
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL good_busy_mid: got %b required 1", busy); end
        tests++; if (parallelValid !== 1'b0) begin failed++; $display("FAIL good_pv_early: got %b required 0", parallelValid); end
      end
    end
    drive('0, 1'b0, 1'b0);
    tests++; if (parallelValid !== 1'b1) begin failed++; $display("FAIL good_pv: got %b required 1", parallelValid); end
    tests++; if (parallelOut[15:0] !== 16'h0001) begin failed++; $display("FAIL good_word0: got %h required 0001", parallelOut[15:0]); end
    tests++; if (parallelOut[159:144] !== 16'h000A) begin failed++; $display("FAIL good_word9: got %h required 000a", parallelOut[159:144]); end
    tests++; if (parallelOut !== exp_out) begin failed++; $display("FAIL good_frame: got %h required %h", parallelOut, exp_out); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL good_busy_end: got %b required 0", busy); end
    settle();
    tests++; if (pv_cnt - pv0 !== 1 || fe_cnt - fe0 !== 0) begin failed++; $display("FAIL good_pulses: got pv=%0d fe=%0d required pv=1 fe=0", pv_cnt - pv0, fe_cnt - fe0); end
  endtask

  task automatic test_short_frame();
    int pv0;
    pv0 = pv_cnt;
    for (int i = 0; i < 4; i++) drive(16'h0011 + DW'(i), 1'b1, i == 3);
    drive('0, 1'b0, 1'b0);
    tests++; if (frameError !== 1'b1) begin failed++; $display("FAIL short_fe: got %b required 1", frameError); end
    tests++; if (parallelValid !== 1'b0) begin failed++; $display("FAIL short_pv: got %b required 0", parallelValid); end
    tests++; if (parallelOut !== exp_out) begin failed++; $display("FAIL short_out: got %h required %h", parallelOut, exp_out); end
    drive('0, 1'b0, 1'b0);
    tests++; if (frameError !== 1'b0) begin failed++; $display("FAIL short_fe_width: got %b required 0", frameError); end
    settle();
    tests++; if (pv_cnt !== pv0) begin failed++; $display("FAIL short_no_pv: got %0d pulses required 0", pv_cnt - pv0); end
  endtask

  task automatic test_long_frame();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 13; i++) begin
      drive(16'h0021 + DW'(i), 1'b1, i == 12);
      if (i == 10) begin
        tests++; if (frameError !== 1'b1) begin failed++; $display("FAIL long_fe_at_10: got %b required 1", frameError); end
      end
      if (i == 12) begin
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL long_busy_discard: got %b required 1", busy); end
      end
    end
    drive('0, 1'b0, 1'b0);
    tests++; if (frameError !== 1'b0) begin failed++; $display("FAIL long_fe_at_13: got %b required 0", frameError); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL long_busy_end: got %b required 0", busy); end
    tests++; if (parallelOut !== exp_out) begin failed++; $display("FAIL long_out: got %h required %h", parallelOut, exp_out); end
    settle();
    tests++; if (fe_cnt - fe0 !== 1 || pv_cnt - pv0 !== 0) begin failed++; $display("FAIL long_pulses: got fe=%0d pv=%0d required fe=1 pv=0", fe_cnt - fe0, pv_cnt - pv0); end
  endtask

  task automatic test_back_to_back();
    int pv0, fe0;
    pv0 = pv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < NW; i++) drive(16'h0031 + DW'(i), 1'b1, i == NW - 1);
    for (int i = 0; i < NW; i++) begin
      drive(16'h0041 + DW'(i), 1'b1, i == NW - 1);
      if (i == 0) begin
        tests++; if (parallelValid !== 1'b1) begin failed++; $display("FAIL b2b_first_pv: got %b required 1", parallelValid); end
        tests++; if (parallelOut[15:0] !== 16'h0031) begin failed++; $display("FAIL b2b_first_word0: got %h required 0031", parallelOut[15:0]); end
      end
      if (i == 2 || i == 5) begin
        @(negedge clk);
        serialValid = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    make_frame(16'h0041);
    drive('0, 1'b0, 1'b0);
    tests++; if (parallelValid !== 1'b1) begin failed++; $display("FAIL b2b_second_pv: got %b required 1", parallelValid); end
    tests++; if (parallelOut !== exp_out) begin failed++; $display("FAIL b2b_second_out: got %h required %h", parallelOut, exp_out); end
    settle();
    tests++; if (pv_cnt - pv0 !== 2 || fe_cnt - fe0 !== 0) begin failed++; $display("FAIL b2b_pulses: got pv=%0d fe=%0d required pv=2 fe=0", pv_cnt - pv0, fe_cnt - fe0); end
  endtask

  task automatic test_reset_midframe();
    int pv0, fe0;
    for (int i = 0; i < 5; i++) drive(16'h0051 + DW'(i), 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1; serialIn = 16'hBEEF; serialValid = 1'b1; serialLast = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
    tests++; if (parallelOut !== '0) begin failed++; $display("FAIL rst_mid_out: got %h required 0", parallelOut); end
    reset = 1'b0; serialValid = 1'b0; serialLast = 1'b0;
    #1;
    pv0 = pv_cnt; fe0 = fe_cnt;
    make_frame(16'h0100);
    for (int i = 0; i < NW; i++) drive(16'h0100 + DW'(i), 1'b1, i == NW - 1);
    drive('0, 1'b0, 1'b0);
    tests++; if (parallelValid !== 1'b1) begin failed++; $display("FAIL rst_mid_pv: got %b required 1", parallelValid); end
    tests++; if (parallelOut[15:0] !== 16'h0100) begin failed++; $display("FAIL rst_mid_word0: got %h required 0100", parallelOut[15:0]); end
    tests++; if (parallelOut !== exp_out) begin failed++; $display("FAIL rst_mid_frame: got %h required %h", parallelOut, exp_out); end
    settle();
    tests++; if (fe_cnt !== fe0 || pv_cnt - pv0 !== 1) begin failed++; $display("FAIL rst_mid_pulses: got fe=%0d pv=%0d required fe=0 pv=1", fe_cnt - fe0, pv_cnt - pv0); end
  endtask

  task automatic test_single_word();
    drive(16'h0077, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b0);
    tests++; if (frameError !== 1'b1) begin failed++; $display("FAIL single_fe: got %b required 1", frameError); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL single_busy: got %b required 0", busy); end
    tests++; if (parallelValid !== 1'b0) begin failed++; $display("FAIL single_pv: got %b required 0", parallelValid); end
    tests++; if (parallelOut !== exp_out) begin failed++; $display("FAIL single_out: got %h required %h", parallelOut, exp_out); end
    settle();
  endtask

  initial begin
    exp_out = '0;
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_back_to_back();
    test_reset_midframe();
    test_single_word();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
